// File: rtl/polyline_sequencer.sv
// Polyline sequencer: parses a count + (x,y) word stream into a 4-entry point FIFO
// and issues one line-drawer segment per consecutive point pair. Optional macro
// POLYLINE_CLOSE_EN adds a closing segment (last point -> first point) for N>=3.
module polyline_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    output logic        accel_can_read,
    output logic        accel_can_write,
    input  logic        accel_read_enable,
    input  logic        accel_write_enable,
    output logic [15:0] accel_read_data,
    input  logic [15:0] accel_write_data,
    output logic        line_drawer_start,
    input  logic        line_drawer_ready,
    output logic [15:0] line_drawer_x1,
    output logic [15:0] line_drawer_y1,
    output logic [15:0] line_drawer_x2,
    output logic [15:0] line_drawer_y2,
    output logic        busy
);
    // Handshake: a write word is consumed on a rising edge where
    // accel_can_write && accel_write_enable; can_write never depends on write_enable.

    typedef enum logic [1:0] {P_COUNT, P_X, P_Y} pstate_t;
`ifdef POLYLINE_CLOSE_EN
    typedef enum logic [2:0] {S_IDLE, S_FIRST, S_NEXT, S_START, S_GUARD, S_BUSY, S_CLOSE} sstate_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_FIRST, S_NEXT, S_START, S_GUARD, S_BUSY} sstate_t;
`endif

    pstate_t     pstate_q, pstate_d;
    sstate_t     state_q, state_d;
    logic [15:0] prem_q, x_stage_q, seq_left_q;
    logic [31:0] fifo_mem_q [4];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  fifo_cnt_q;
    logic [31:0] prev_q, cur_q, fifo_head, seg_a, seg_b;
    logic [15:0] x1_q, y1_q, x2_q, y2_q;
    logic        busy_q, start_q, start_d;
    logic        fifo_empty, fifo_full, wr_fire, push, pop, count_take, load_seg;
`ifdef POLYLINE_CLOSE_EN
    logic [31:0] first_q;
    logic        close_pending_q;
`endif
    logic        unused_read_en;

    assign unused_read_en    = accel_read_enable;
    assign accel_can_read    = 1'b0;
    assign accel_read_data   = 16'd0;
    assign busy              = busy_q;
    assign line_drawer_start = start_q;
    assign line_drawer_x1    = x1_q;
    assign line_drawer_y1    = y1_q;
    assign line_drawer_x2    = x2_q;
    assign line_drawer_y2    = y2_q;

    assign fifo_empty = (fifo_cnt_q == 3'd0);
    assign fifo_full  = (fifo_cnt_q == 3'd4);
    assign fifo_head  = fifo_mem_q[rd_ptr_q];
    assign wr_fire    = accel_can_write && accel_write_enable;
    assign push       = wr_fire && (pstate_q == P_Y);
    assign count_take = wr_fire && (pstate_q == P_COUNT) && (accel_write_data != 16'd0);

    // Parser: state register / next state / outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pstate_q <= P_COUNT;
        else        pstate_q <= pstate_d;
    end

    always_comb begin
        pstate_d = pstate_q;
        unique case (pstate_q)
            P_COUNT: if (count_take) pstate_d = P_X;
            P_X:     if (wr_fire) pstate_d = P_Y;
            P_Y:     if (wr_fire) pstate_d = (prem_q == 16'd1) ? P_COUNT : P_X;
            default: pstate_d = P_COUNT;
        endcase
    end

    always_comb begin
        accel_can_write = 1'b0;
        if (pstate_q == P_COUNT) accel_can_write = !busy_q && fifo_empty;
        else                     accel_can_write = !fifo_full;
    end

    // Sequencer: state register / next state / outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (busy_q) state_d = S_FIRST;
            S_FIRST: if (!fifo_empty) state_d = (seq_left_q == 16'd1) ? S_START : S_NEXT;
            S_NEXT:  if (!fifo_empty) state_d = S_START;
            S_START: state_d = S_GUARD;
            S_GUARD: state_d = S_BUSY;
            S_BUSY: begin
                if (line_drawer_ready) begin
                    if (seq_left_q != 16'd0) state_d = S_NEXT;
`ifdef POLYLINE_CLOSE_EN
                    else if (close_pending_q) state_d = S_CLOSE;
`endif
                    else state_d = S_IDLE;
                end
            end
`ifdef POLYLINE_CLOSE_EN
            S_CLOSE: state_d = S_START;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pop      = 1'b0;
        load_seg = 1'b0;
        seg_a    = prev_q;
        seg_b    = fifo_head;
        start_d  = (state_q == S_START);
        unique case (state_q)
            S_FIRST: begin
                pop      = !fifo_empty;
                load_seg = !fifo_empty && (seq_left_q == 16'd1);
                seg_a    = fifo_head;
            end
            S_NEXT: begin
                pop      = !fifo_empty;
                load_seg = !fifo_empty;
            end
`ifdef POLYLINE_CLOSE_EN
            S_CLOSE: begin
                load_seg = 1'b1;
                seg_b    = first_q;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= {x_stage_q, accel_write_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prem_q     <= 16'd0;
            x_stage_q  <= 16'd0;
            seq_left_q <= 16'd0;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            fifo_cnt_q <= 3'd0;
            prev_q     <= 32'd0;
            cur_q      <= 32'd0;
            {x1_q, y1_q, x2_q, y2_q} <= 64'd0;
            busy_q     <= 1'b0;
            start_q    <= 1'b0;
`ifdef POLYLINE_CLOSE_EN
            first_q         <= 32'd0;
            close_pending_q <= 1'b0;
`endif
        end else begin
            start_q <= start_d;
            if (wr_fire && pstate_q == P_X) x_stage_q <= accel_write_data;
            if (count_take) begin
                prem_q     <= accel_write_data;
                seq_left_q <= accel_write_data;
                busy_q     <= 1'b1;
`ifdef POLYLINE_CLOSE_EN
                close_pending_q <= (accel_write_data >= 16'd3);
`endif
            end
            if (push) begin
                prem_q   <= prem_q - 16'd1;
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + 2'd1;
                seq_left_q <= seq_left_q - 16'd1;
                cur_q      <= fifo_head;
            end
            // Simultaneous push and pop leaves the occupancy unchanged
            if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + 3'd1;
            else if (pop && !push) fifo_cnt_q <= fifo_cnt_q - 3'd1;
            if (state_q == S_FIRST && pop) begin
                prev_q <= fifo_head;
`ifdef POLYLINE_CLOSE_EN
                first_q <= fifo_head;
`endif
            end
`ifdef POLYLINE_CLOSE_EN
            if (state_q == S_CLOSE) begin
                close_pending_q <= 1'b0;
                cur_q           <= first_q;
            end
`endif
            if (load_seg) {x1_q, y1_q, x2_q, y2_q} <= {seg_a, seg_b};
            if (state_q == S_BUSY && line_drawer_ready) prev_q <= cur_q;
            if (state_q != S_IDLE && state_d == S_IDLE) busy_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_polyline_sequencer.sv
// Testbench for polyline_sequencer: drawer model plus expected-segment scoreboard.
// Build with +define+POLYLINE_CLOSE_EN to expect closing segments.
module tb_polyline_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        can_read, can_write, we = 1'b0, re = 1'b0;
  logic [15:0] rdata, wdata = 16'd0;
  logic        start, ready = 1'b1, busy;
  logic [15:0] x1, y1, x2, y2;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] cur_seg;
  int  drawer_delay = 3;
  int  dcnt = 0;
  bit  drawer_hold = 1'b0;
  bit  in_seg = 1'b0;
  bit  prev_start = 1'b0;
  int  seg_seen = 0;
  int  words_taken = 0;

  always #5 clk = ~clk;

  polyline_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .accel_can_read(can_read), .accel_can_write(can_write),
    .accel_read_enable(re), .accel_write_enable(we),
    .accel_read_data(rdata), .accel_write_data(wdata),
    .line_drawer_start(start), .line_drawer_ready(ready),
    .line_drawer_x1(x1), .line_drawer_y1(y1),
    .line_drawer_x2(x2), .line_drawer_y2(y2),
    .busy(busy)
  );

  // Drawer model and scoreboard consumer, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      ready = 1'b1;
      in_seg = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (start) begin
        checks++;
        if (prev_start) begin
          errors++;
          $display("FAIL start_width start=1 for 2 cycles, required 1 cycle");
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_start seg=%h required=no start", {x1, y1, x2, y2});
        end else begin
          cur_seg = exp_q.pop_front();
          if ({x1, y1, x2, y2} !== cur_seg) begin
            errors++;
            $display("FAIL segment got=%h required=%h", {x1, y1, x2, y2}, cur_seg);
          end
        end
        cur_seg = {x1, y1, x2, y2};
        in_seg = 1'b1;
        ready = 1'b0;
        dcnt = drawer_delay;
        seg_seen++;
      end else begin
        if (in_seg) begin
          checks++;
          if ({x1, y1, x2, y2} !== cur_seg) begin
            errors++;
            $display("FAIL endpoint_stable got=%h required=%h", {x1, y1, x2, y2}, cur_seg);
          end
        end
        if (drawer_hold) ready = 1'b0;
        else if (!ready) begin
          if (dcnt <= 1) begin
            ready = 1'b1;
            in_seg = 1'b0;
          end else dcnt--;
        end
      end
      prev_start = start;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic write_word(input logic [15:0] w);
    int t;
    t = 0;
    @(negedge clk);
    wdata = w;
    we = 1'b1;
    while (!can_write && t < 3000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 3000) begin
      errors++;
      $display("FAIL write_timeout word=%0d can_write=0 required=1", w);
      we = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      words_taken++;
    end
  endtask

  task automatic write_poly(input logic [31:0] pts[$], input bit model);
    int n;
    n = pts.size();
    if (model) begin
      if (n == 1) exp_q.push_back({pts[0], pts[0]});
      for (int k = 1; k < n; k++) exp_q.push_back({pts[k-1], pts[k]});
`ifdef POLYLINE_CLOSE_EN
      if (n >= 3) exp_q.push_back({pts[n-1], pts[0]});
`endif
    end
    write_word(16'(n));
    for (int k = 0; k < n; k++) begin
      write_word(pts[k][31:16]);
      write_word(pts[k][15:0]);
    end
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0 || !ready) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 5000) begin
      errors++;
      $display("FAIL %s_idle busy=%0b pending=%0d required busy=0 pending=0", name, busy, exp_q.size());
    end
  endtask

  task automatic wait_segs(input int target);
    int t;
    t = 0;
    while (seg_seen < target && t < 3000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (seg_seen < target) begin
      errors++;
      $display("FAIL seg_wait seen=%0d required=%0d", seg_seen, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({can_read, rdata, start, busy} !== 19'd0) begin
      errors++;
      $display("FAIL reset_flags can_read=%0b rdata=%0d start=%0b busy=%0b required all 0", can_read, rdata, start, busy);
    end
    checks++;
    if ({x1, y1, x2, y2} !== 64'd0) begin
      errors++;
      $display("FAIL reset_endpoints got=%h required=0", {x1, y1, x2, y2});
    end
    checks++;
    if (can_write !== 1'b1) begin
      errors++;
      $display("FAIL reset_can_write got=%0b required=1", can_write);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_triangle();
    logic [31:0] pts[$];
    drawer_delay = 3;
    pts = '{{16'd0, 16'd0}, {16'd10, 16'd0}, {16'd10, 16'd5}};
    write_poly(pts, 1'b1);
    wait_idle("triangle");
  endtask

  task automatic test_zero_and_dot();
    logic [31:0] pts[$];
    int s0;
    s0 = seg_seen;
    write_word(16'd0);
    @(negedge clk);
    we = 1'b0;
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || can_write !== 1'b1) begin
        errors++;
        $display("FAIL zero_count busy=%0b can_write=%0b required busy=0 can_write=1", busy, can_write);
      end
    end
    checks++;
    if (seg_seen != s0) begin
      errors++;
      $display("FAIL zero_count_starts got=%0d required=0", seg_seen - s0);
    end
    pts = '{{16'd7, 16'd9}};
    write_poly(pts, 1'b1);
    wait_idle("dot");
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL dot_busy got=%0b required=0", busy);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] pts[$];
    int s0, w0;
    s0 = seg_seen;
    w0 = words_taken;
    drawer_delay = 2;
    for (int k = 0; k < 8; k++) pts.push_back({16'(k * 3 + 1), 16'(100 - k)});
    drawer_hold = 1'b1;
    fork
      write_poly(pts, 1'b1);
      begin
        repeat (60) @(negedge clk);
        checks++;
        if (can_write !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL stall_flags can_write=%0b busy=%0b required can_write=0 busy=1", can_write, busy);
        end
        checks++;
        if (words_taken - w0 < 13 || words_taken - w0 > 14) begin
          errors++;
          $display("FAIL stall_words got=%0d required=13..14", words_taken - w0);
        end
        checks++;
        if (seg_seen != s0 + 1) begin
          errors++;
          $display("FAIL stall_segments got=%0d required=1", seg_seen - s0);
        end
        drawer_hold = 1'b0;
      end
    join
    wait_idle("backpressure");
  endtask

  task automatic test_busy_count();
    logic [31:0] pts[$];
    int s0;
    s0 = seg_seen;
    drawer_delay = 20;
    pts = '{{16'd1, 16'd1}, {16'd2, 16'd2}};
    write_poly(pts, 1'b1);
    wait_segs(s0 + 1);
    repeat (5) begin
      @(negedge clk);
      wdata = 16'd5;
      we = 1'b1;
      checks++;
      if (busy !== 1'b1 || can_write !== 1'b0) begin
        errors++;
        $display("FAIL count_while_busy busy=%0b can_write=%0b required busy=1 can_write=0", busy, can_write);
      end
    end
    @(negedge clk);
    we = 1'b0;
    wait_idle("busy_count");
    drawer_delay = 3;
    pts = '{{16'd3, 16'd4}};
    write_poly(pts, 1'b1);
    wait_idle("after_busy_count");
  endtask

  task automatic test_reset_midbusy();
    logic [31:0] pts[$];
    int s0;
    s0 = seg_seen;
    drawer_delay = 6;
    pts = '{{16'd20, 16'd21}, {16'd22, 16'd23}, {16'd24, 16'd25}, {16'd26, 16'd27}};
    exp_q.push_back({pts[0], pts[1]});
    exp_q.push_back({pts[1], pts[2]});
    write_poly(pts, 1'b0);
    wait_segs(s0 + 2);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({start, busy} !== 2'b00 || {x1, y1, x2, y2} !== 64'd0) begin
      errors++;
      $display("FAIL reset_in_busy start=%0b busy=%0b seg=%h required all 0", start, busy, {x1, y1, x2, y2});
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_pending got=%0d required=0", exp_q.size());
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || seg_seen != s0 + 2) begin
      errors++;
      $display("FAIL after_reset busy=%0b extra_starts=%0d required busy=0 extra_starts=0", busy, seg_seen - s0 - 2);
    end
    drawer_delay = 3;
    pts = '{{16'd5, 16'd6}, {16'd8, 16'd1}};
    write_poly(pts, 1'b1);
    wait_idle("after_reset");
  endtask

  initial begin
    test_reset();
    test_triangle();
    test_zero_and_dot();
    test_backpressure();
    test_busy_count();
    test_reset_midbusy();
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/polyline_sequencer.md
POLYLINE_SEQUENCER -- requirements
Module: polyline_sequencer

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 accel_can_read  output  1  tied 0.
REQ-004 accel_can_write  output  1  block accepts a write word this cycle.
REQ-005 accel_read_enable  input  1  ignored.
REQ-006 accel_write_enable  input  1  write strobe; a word is consumed only when accel_can_write && accel_write_enable.
REQ-007 accel_read_data  output  16  tied 0.
REQ-008 accel_write_data  input  16  command/coordinate word.
REQ-009 line_drawer_start  output  1  one-cycle pulse launching a segment.
REQ-010 line_drawer_ready  input  1  drawer idle/done.
REQ-011 line_drawer_x1/y1/x2/y2  output  16 each  segment endpoints; stable from the start pulse until the segment completes.
REQ-012 busy  output  1  polyline in progress (count accepted, final segment not yet complete).

Function
REQ-013 Word stream SHALL be: count N (unsigned 16), then N (x,y) pairs; parser states P_COUNT, P_X, P_Y.
REQ-014 In P_COUNT, accel_can_write SHALL be 1 only when busy=0 and the point FIFO is empty.
REQ-015 In P_X/P_Y, accel_can_write SHALL be 1 only when the 4-entry point FIFO is not full; a point SHALL be pushed on the cycle its y word is consumed (x is held in a staging register).
REQ-016 N=0 SHALL be consumed and discarded; the parser stays in P_COUNT, busy stays 0, and no start is issued.
REQ-017 Points remaining SHALL decrement per pushed point; the parser returns to P_COUNT after the Nth y word.
REQ-018 Sequencer states: S_IDLE, S_FIRST, S_NEXT, S_START, S_GUARD, S_BUSY, S_CLOSE.
REQ-019 S_FIRST pops point 0 into prev (and into first when POLYLINE_CLOSE_EN is defined).
REQ-020 S_NEXT pops point k, loads x1,y1=prev and x2,y2=point k, then goes to S_START.
REQ-021 S_START SHALL assert line_drawer_start for exactly one cycle; S_GUARD SHALL wait one cycle; S_BUSY SHALL hold until line_drawer_ready=1, then set prev=point k.
REQ-022 Latency: with the FIFO non-empty, start SHALL occur 2 cycles after S_NEXT is entered.
REQ-023 N=1: one segment with x1=x2 and y1=y2 (a dot) SHALL be issued.
REQ-024 After the segment ending at point N-1 completes, the sequencer SHALL return to S_IDLE (or S_CLOSE per REQ-029), and busy SHALL fall in the same cycle it enters S_IDLE.
REQ-025 Simultaneous FIFO push and pop SHALL preserve the occupancy; the FIFO SHALL never overflow or underflow.
REQ-026 Total segments SHALL equal max(N-1,1) for N>=1.

Reset
REQ-027 On rst_n=0: parser to P_COUNT, sequencer to S_IDLE, FIFO empty, line_drawer_start=0, busy=0, and x1/y1/x2/y2=0, all immediately.
REQ-028 Reset during S_BUSY SHALL abandon the segment; after release, no start SHALL be issued until a new polyline is received.

Configuration
REQ-029 With POLYLINE_CLOSE_EN defined and N>=3, S_CLOSE SHALL issue one extra segment prev->first using the S_START/S_GUARD/S_BUSY sequence before S_IDLE; without the macro, S_CLOSE and the first register SHALL not exist and no closing segment is issued.
REQ-030 N<=2 SHALL never produce a closing segment.

Verification
REQ-031 Write N=3,(0,0),(10,0),(10,5), with drawer ready 3 cycles after each start -> segments (0,0)-(10,0), (10,0)-(10,5); with POLYLINE_CLOSE_EN, an additional (10,5)-(0,0).
REQ-032 N=0, then N=1,(7,9) -> no start for N=0; exactly one segment (7,9)-(7,9); busy returns to 0.
REQ-033 N=8 with drawer held not-ready -> accel_can_write drops after 4 buffered points plus a staged x; all 7 segments are drawn in order once ready toggles.
REQ-034 Attempt a count write while busy=1 -> accel_can_write=0 and the word is not consumed.
REQ-035 Assert rst_n low during the S_BUSY of segment 2 of N=4 -> outputs zero immediately; no start after release; a fresh N=2 then draws correctly.
